// File: rtl/icache_assoc.sv
// Purpose : N-way set-associative instruction cache with multi-word blocks and round-robin replacement.
// Latency : hits are combinational (same cycle); a miss costs WORDS memory transfers plus one commit cycle.
// Backpr. : memory stalls the fill through iwait; the datapath holds imemREN until ihit is returned.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   flush             invalidate every line (aborts an in-flight fill)
//   imemREN/imemaddr  fetch request and byte address (bits [1:0] ignored)
//   ihit/imemload     hit strobe and instruction word (0 when no hit)
//   iREN/iaddr        memory read request and word-aligned address
//   iwait/iload       memory busy and read data
//   hit_count/miss_count  performance counters, present only when ICACHE_STATS_EN is defined
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int OW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] BLK_MASK = ~(32'(WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t state, state_nxt;

    logic [WAYS-1:0]  valid [SETS];
    logic [WW-1:0]    vptr  [SETS];
    logic [TAG_W-1:0] tags  [SETS][WAYS];
    logic [31:0]      data  [SETS][WAYS][WORDS];

    // Request decode
    logic [OW-1:0]    req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_bits;

    assign req_idx = imemaddr[2+OFF_W +: IDX_W];
    assign req_tag = imemaddr[31 -: TAG_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    generate
        if (WORDS > 1) begin : g_off
            assign req_off = imemaddr[2 +: OFF_W];
        end else begin : g_no_off
            assign req_off = '0;
        end
    endgenerate

    // Fill context, captured when a miss leaves IDLE
    logic [31:0]      fill_base;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [WW-1:0]    fill_way;
    logic [OW-1:0]    cnt;
    logic             cnt_last;
    logic             start_fill;

    assign cnt_last   = (cnt == OW'(WORDS - 1));
    assign start_fill = (state == IDLE) && (state_nxt == FILL);

    // Tag lookup across the indexed set
    logic          hit_any;
    logic [WW-1:0] hit_way;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && (tags[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Victim choice: lowest invalid way wins, else the set's round-robin pointer
    logic          has_inv;
    logic [WW-1:0] inv_way;
    logic [WW-1:0] pick_way;

    always_comb begin
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
        pick_way = has_inv ? inv_way : vptr[req_idx];
    end

    // FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. Flush takes priority over starting a fill.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!flush && imemREN && !hit_any) state_nxt = FILL;
            FILL: begin
                if (flush)                  state_nxt = IDLE;
                else if (!iwait && cnt_last) state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (state)
            IDLE: begin
                if (imemREN && hit_any && !flush) begin
                    ihit     = 1'b1;
                    imemload = data[req_idx][hit_way][req_off];
                end
            end
            FILL: begin
                iREN  = 1'b1;
                // Base is block aligned, so OR-ing the word offset never carries out of the block
                iaddr = fill_base | {30'(cnt), 2'b00};
            end
            default: ;
        endcase
    end

    // Fill context and word counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_base <= '0;
            fill_idx  <= '0;
            fill_tag  <= '0;
            fill_way  <= '0;
            cnt       <= '0;
        end else if (start_fill) begin
            fill_base <= imemaddr & BLK_MASK;
            fill_idx  <= req_idx;
            fill_tag  <= req_tag;
            fill_way  <= pick_way;
            cnt       <= '0;
        end else if ((state == FILL) && !iwait && !cnt_last) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Valid bits and victim pointers; the line only becomes valid in COMMIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                vptr[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
            end
        end else if (state == COMMIT) begin
            valid[fill_idx][fill_way] <= 1'b1;
            vptr[fill_idx]            <= (WAYS == 1) ? '0 : fill_way + 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them
    always_ff @(posedge CLK) begin
        if ((state == FILL) && !iwait && !flush) begin
            data[fill_idx][fill_way][cnt] <= iload;
        end
        if (state == COMMIT) begin
            tags[fill_idx][fill_way] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)       hit_count  <= hit_count + 32'd1;
            if (start_fill) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Purpose : directed table-driven bench for icache_assoc (default config and a 4-set direct-mapped, 1-word config).
// Latency : one table row per clock; outputs sampled 2 time units after the falling edge.
// Backpr. : memory wait states are scripted per row through iwait.
module tb_icache_assoc;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    // DUT A: SETS=8, WAYS=2, WORDS=2
    logic        a_flush, a_ren, a_ihit, a_iren, a_iwait;
    logic [31:0] a_addr, a_load, a_iaddr, a_iload;
    // DUT B: SETS=4, WAYS=1, WORDS=1
    logic        b_flush, b_ren, b_ihit, b_iren, b_iwait;
    logic [31:0] b_addr, b_load, b_iaddr, b_iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] a_hc, a_mc, b_hc, b_mc;
`endif

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2)) dut_a (
        .CLK(CLK), .RST(RST), .flush(a_flush), .imemREN(a_ren), .imemaddr(a_addr),
        .ihit(a_ihit), .imemload(a_load), .iREN(a_iren), .iaddr(a_iaddr),
        .iwait(a_iwait), .iload(a_iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(a_hc), .miss_count(a_mc)
`endif
    );

    icache_assoc #(.SETS(4), .WAYS(1), .WORDS(1)) dut_b (
        .CLK(CLK), .RST(RST), .flush(b_flush), .imemREN(b_ren), .imemaddr(b_addr),
        .ihit(b_ihit), .imemload(b_load), .iREN(b_iren), .iaddr(b_iaddr),
        .iwait(b_iwait), .iload(b_iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(b_hc), .miss_count(b_mc)
`endif
    );

    typedef struct {
        logic        sel;
        logic        ren;
        logic [31:0] addr;
        logic        flush;
        logic        iwait;
        logic [31:0] iload;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } row_t;

    row_t tv[$];
    int   total = 0;
    int   bad   = 0;

    function automatic row_t mk(input logic sel, input logic ren, input logic [31:0] addr,
                                input logic flush, input logic iwait, input logic [31:0] iload,
                                input logic e_hit, input logic [31:0] e_load,
                                input logic e_iren, input logic [31:0] e_iaddr);
        row_t r;
        r.sel = sel; r.ren = ren; r.addr = addr; r.flush = flush; r.iwait = iwait; r.iload = iload;
        r.e_hit = e_hit; r.e_load = e_load; r.e_iren = e_iren; r.e_iaddr = e_iaddr;
        return r;
    endfunction

    // Fetch in IDLE: expect hit/load, no memory request
    function automatic row_t rq(input logic sel, input logic [31:0] addr, input logic h, input logic [31:0] d);
        return mk(sel, 1'b1, addr, 1'b0, 1'b1, 32'hDEADBEEF, h, d, 1'b0, 32'h0);
    endfunction

    // FILL cycle: memory request at ea
    function automatic row_t fl(input logic sel, input logic [31:0] addr, input logic w,
                                input logic [31:0] d, input logic [31:0] ea);
        return mk(sel, 1'b1, addr, 1'b0, w, d, 1'b0, 32'h0, 1'b1, ea);
    endfunction

    // COMMIT cycle: everything quiet
    function automatic row_t cm(input logic sel, input logic [31:0] addr);
        return mk(sel, 1'b1, addr, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic idle_inputs();
        a_flush = 1'b0; a_ren = 1'b0; a_addr = 32'h0; a_iwait = 1'b1; a_iload = 32'h0;
        b_flush = 1'b0; b_ren = 1'b0; b_addr = 32'h0; b_iwait = 1'b1; b_iload = 32'h0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic run_table(input string ph);
        logic [65:0] got, exp;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge CLK);
            idle_inputs();
            if (tv[i].sel) begin
                b_ren = tv[i].ren; b_addr = tv[i].addr; b_flush = tv[i].flush;
                b_iwait = tv[i].iwait; b_iload = tv[i].iload;
            end else begin
                a_ren = tv[i].ren; a_addr = tv[i].addr; a_flush = tv[i].flush;
                a_iwait = tv[i].iwait; a_iload = tv[i].iload;
            end
            #2;
            got = tv[i].sel ? {b_ihit, b_load, b_iren, b_iaddr} : {a_ihit, a_load, a_iren, a_iaddr};
            exp = {tv[i].e_hit, tv[i].e_load, tv[i].e_iren, tv[i].e_iaddr};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s[%0d]: got hit=%b load=%h iren=%b iaddr=%h want hit=%b load=%h iren=%b iaddr=%h",
                         ph, i, got[65], got[64:33], got[32], got[31:0],
                         exp[65], exp[64:33], exp[32], exp[31:0]);
            end
        end
        tv.delete();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        a_ren = 1'b1; a_addr = 32'h40;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        chk("rst_a_ihit",  32'(a_ihit), 32'h0);
        chk("rst_a_load",  a_load,      32'h0);
        chk("rst_a_iren",  32'(a_iren), 32'h0);
        chk("rst_a_iaddr", a_iaddr,     32'h0);
        chk("rst_b_iren",  32'(b_iren), 32'h0);
        chk("rst_b_iaddr", b_iaddr,     32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count",  a_hc, 32'h0);
        chk("rst_miss_count", a_mc, 32'h0);
`endif
        a_ren = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        // Defaults, associativity, redirect during fill, flush in FILL and IDLE
        tv.push_back(rq(0, 32'h40, 0, 32'h0));
        tv.push_back(fl(0, 32'h40, 1, 32'hDEADBEEF, 32'h40));
        tv.push_back(fl(0, 32'h40, 0, 32'hAAAA0000, 32'h40));
        tv.push_back(fl(0, 32'h40, 1, 32'hDEADBEEF, 32'h44));
        tv.push_back(fl(0, 32'h40, 0, 32'hAAAA0004, 32'h44));
        tv.push_back(cm(0, 32'h40));
        tv.push_back(rq(0, 32'h40, 1, 32'hAAAA0000));
        tv.push_back(rq(0, 32'h44, 1, 32'hAAAA0004));
        tv.push_back(rq(0, 32'h80, 0, 32'h0));
        tv.push_back(fl(0, 32'h80, 0, 32'hBBBB0080, 32'h80));
        tv.push_back(fl(0, 32'h80, 0, 32'hBBBB0084, 32'h84));
        tv.push_back(cm(0, 32'h80));
        tv.push_back(rq(0, 32'h80, 1, 32'hBBBB0080));
        tv.push_back(rq(0, 32'h40, 1, 32'hAAAA0000));
        tv.push_back(rq(0, 32'hC0, 0, 32'h0));
        tv.push_back(fl(0, 32'hC0, 0, 32'hCCCC00C0, 32'hC0));
        tv.push_back(fl(0, 32'hC0, 0, 32'hCCCC00C4, 32'hC4));
        tv.push_back(cm(0, 32'hC0));
        tv.push_back(rq(0, 32'hC4, 1, 32'hCCCC00C4));
        tv.push_back(rq(0, 32'h84, 1, 32'hBBBB0084));
        tv.push_back(rq(0, 32'h40, 0, 32'h0));
        tv.push_back(fl(0, 32'h100, 0, 32'hAAAA0000, 32'h40));
        tv.push_back(fl(0, 32'h100, 0, 32'hAAAA0004, 32'h44));
        tv.push_back(cm(0, 32'h100));
        tv.push_back(rq(0, 32'h100, 0, 32'h0));
        tv.push_back(fl(0, 32'h100, 0, 32'hDDDD0100, 32'h100));
        tv.push_back(fl(0, 32'h100, 0, 32'hDDDD0104, 32'h104));
        tv.push_back(cm(0, 32'h100));
        tv.push_back(rq(0, 32'h104, 1, 32'hDDDD0104));
        tv.push_back(rq(0, 32'h40, 1, 32'hAAAA0000));
        tv.push_back(rq(0, 32'hC0, 0, 32'h0));
        tv.push_back(fl(0, 32'hC0, 0, 32'hEEEE00C0, 32'hC0));
        tv.push_back(mk(0, 1, 32'hC0, 1, 1, 32'hDEADBEEF, 0, 32'h0, 1, 32'hC4));
        tv.push_back(mk(0, 0, 32'hC0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0));
        tv.push_back(rq(0, 32'hC0, 0, 32'h0));
        tv.push_back(fl(0, 32'hC0, 0, 32'hEEEE00C0, 32'hC0));
        tv.push_back(fl(0, 32'hC0, 0, 32'hEEEE00C4, 32'hC4));
        tv.push_back(cm(0, 32'hC0));
        tv.push_back(rq(0, 32'h104, 0, 32'h0));
        tv.push_back(fl(0, 32'h104, 0, 32'hDDDD0100, 32'h100));
        tv.push_back(fl(0, 32'h104, 0, 32'hDDDD0104, 32'h104));
        tv.push_back(cm(0, 32'h104));
        tv.push_back(rq(0, 32'h104, 1, 32'hDDDD0104));
        tv.push_back(rq(0, 32'hC4, 1, 32'hEEEE00C4));
        tv.push_back(mk(0, 1, 32'h104, 1, 1, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0));
        tv.push_back(rq(0, 32'h100, 0, 32'h0));
        tv.push_back(fl(0, 32'h100, 1, 32'hDEADBEEF, 32'h100));
        run_table("main");

        // Asynchronous reset in the middle of a stalled fill
        @(negedge CLK);
        a_ren = 1'b1; a_addr = 32'h100; a_iwait = 1'b1;
        #1;
        chk("fill_before_rst_iren", 32'(a_iren), 32'h1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_iren",  32'(a_iren), 32'h0);
        chk("async_rst_ihit",  32'(a_ihit), 32'h0);
        chk("async_rst_load",  a_load,      32'h0);
        chk("async_rst_iaddr", a_iaddr,     32'h0);
        @(negedge CLK);
        RST = 1'b0;
        a_ren = 1'b0;

        // After reset: 0x40 misses again; then the top-of-memory block
        tv.push_back(rq(0, 32'h40, 0, 32'h0));
        tv.push_back(fl(0, 32'h40, 0, 32'hAAAA0000, 32'h40));
        tv.push_back(fl(0, 32'h40, 0, 32'hAAAA0004, 32'h44));
        tv.push_back(cm(0, 32'h40));
        tv.push_back(rq(0, 32'h40, 1, 32'hAAAA0000));
        tv.push_back(rq(0, 32'h44, 1, 32'hAAAA0004));
        tv.push_back(rq(0, 32'hFFFFFFF8, 0, 32'h0));
        tv.push_back(fl(0, 32'hFFFFFFF8, 0, 32'h99990000, 32'hFFFFFFF8));
        tv.push_back(fl(0, 32'hFFFFFFF8, 0, 32'h99990004, 32'hFFFFFFFC));
        tv.push_back(cm(0, 32'hFFFFFFF8));
        tv.push_back(rq(0, 32'hFFFFFFFC, 1, 32'h99990004));
        tv.push_back(rq(0, 32'hFFFFFFF8, 1, 32'h99990000));
        tv.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 0, 32'h0));
        run_table("post_rst");
`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        #2;
        chk("a_hit_count",  a_hc, 32'd4);
        chk("a_miss_count", a_mc, 32'd2);
`endif

        // Direct-mapped single-word config: 0x0 and 0x10 collide in set 0
        tv.push_back(rq(1, 32'h0, 0, 32'h0));
        tv.push_back(fl(1, 32'h0, 0, 32'h11110000, 32'h0));
        tv.push_back(cm(1, 32'h0));
        tv.push_back(rq(1, 32'h0, 1, 32'h11110000));
        tv.push_back(rq(1, 32'h10, 0, 32'h0));
        tv.push_back(fl(1, 32'h10, 0, 32'h22220010, 32'h10));
        tv.push_back(cm(1, 32'h10));
        tv.push_back(rq(1, 32'h10, 1, 32'h22220010));
        tv.push_back(rq(1, 32'h0, 0, 32'h0));
        tv.push_back(fl(1, 32'h0, 0, 32'h11110000, 32'h0));
        tv.push_back(cm(1, 32'h0));
        tv.push_back(rq(1, 32'h0, 1, 32'h11110000));
        tv.push_back(rq(1, 32'h10, 0, 32'h0));
        run_table("dm");
`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        #2;
        chk("b_hit_count",  b_hc, 32'd3);
        chk("b_miss_count", b_mc, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
